fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage and IF/ID pipeline register of the 20-bit pipelined core.
//  Sequences the PC and drives a synchronous-read instruction memory (1-cycle latency).
//  Delivers {instr, pc, valid} to decode, where opcode[2:0] and immediates are extracted.
//  Honors hazard-unit stalls without losing in-flight words; flushes on branch redirect.
// PARAMETERS
//  DATA_WIDTH  20  instruction width, bits
//  ADDR_WIDTH  10  instruction memory word-address width
//  RESET_PC    0   first fetch address after reset
// PORTS
//  clk            in   1           clock; all state updates on rising edge
//  rst_n          in   1           asynchronous reset, active low
//  stall_i        in   1           decode cannot accept; hold IF/ID contents
//  redirect_i     in   1           taken branch (bltp/bgep) resolved downstream
//  redirect_pc_i  in   ADDR_WIDTH  branch target word address
//  imem_req_o     out  1           memory read enable this cycle
//  imem_addr_o    out  ADDR_WIDTH  memory read address
//  imem_rdata_i   in   DATA_WIDTH  read data; valid the cycle after the request
//  ifid_valid_o   out  1           IF/ID holds a real instruction
//  ifid_instr_o   out  DATA_WIDTH  instruction to decode; NOP_INSTR when invalid
//  ifid_pc_o      out  ADDR_WIDTH  address of ifid_instr_o
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - pc_q=RESET_PC; req_valid_q=0; skid_valid_q=0.
//  - ifid_valid_o=0, ifid_instr_o=NOP_INSTR (20'h0), ifid_pc_o=0.
//  - imem_req_o=0, imem_addr_o=RESET_PC while in reset.
//  - First request in the first cycle after deassertion.
//  Internal state:
//  - pc_q: next address to request.
//  - req_valid_q/req_pc_q: request issued last cycle; its data is on imem_rdata_i now.
//  - skid_valid_q/skid_instr_q/skid_pc_q: one-entry buffer for data returned during a stall.
//  Address path:
//  - imem_addr_o = redirect_i ? redirect_pc_i : pc_q (combinational).
//  - imem_req_o = redirect_i | ~stall_i.
//  Priority per cycle: redirect > stall > run.
//  REDIRECT (redirect_i=1, stall_i ignored):
//  - Request issued at redirect_pc_i; pc_q<=redirect_pc_i+1; req_valid_q<=1, req_pc_q<=redirect_pc_i.
//  - In-flight data discarded; skid_valid_q<=0.
//  - IF/ID flushed: valid 0, instr NOP_INSTR, pc holds.
//  - Penalty is exactly one bubble; the target appears in IF/ID 2 edges after the redirect edge.
//  STALL (stall_i=1, redirect_i=0):
//  - IF/ID holds; no request issued; pc_q holds.
//  - If req_valid_q: skid <= {imem_rdata_i, req_pc_q}, skid_valid_q<=1.
//  - req_valid_q<=0.
//  - Multi-cycle stall: skid holds its contents unchanged.
//  RUN (neither asserted):
//  - IF/ID <= skid if skid_valid_q, else {rdata, req_pc_q, 1} if req_valid_q, else bubble (valid 0, NOP).
//  - skid_valid_q<=0; request at pc_q; pc_q<=pc_q+1; req_valid_q<=1.
//  - skid_valid_q and req_valid_q are never both 1. Assert this; violation is a design error.
//  Throughput: one instruction per cycle in steady state; no bubble on stall release.
//  Arithmetic: pc increment is modulo 2^ADDR_WIDTH (all-ones wraps to 0); no overflow flag.
//  Reset mid-operation: all in-flight and skid data dropped; restart at RESET_PC.
// STRUCTURE
//  pipeline_pkg (shared):
//  - DATA_WIDTH.
//  - NOP_INSTR = 20'h0.
//  - opcode_t enum: OP_ALUI=3'b010, OP_LOAD=3'b011, OP_STORE=3'b100, OP_BRANCH=3'b101.
//  - ifid_t struct {valid, instr, pc}.
//  Sub-module fetch_skid_buf:
//  - One-entry buffer with load/consume/clear.
//  - Instantiated once; PC sequencing and IF/ID logic stay in fetch_stage.
// TESTING (memory model: mem[a]=20'h1000+a, one-cycle read latency)
//  1 Reset release, RESET_PC=0, no stall -> ifid_pc_o 0,1,2,3 on edges 2..5; instr 20'h01000..01003.
//  2 stall_i high 3 cycles while addr 5 in flight -> IF/ID frozen; no imem_req_o; on release ifid shows pc 5 then 6, no gap.
//  3 redirect_i with redirect_pc_i=40 while running -> next edge valid=0, NOP; following edge pc 40, instr 20'h01028.
//  4 redirect_i and stall_i same cycle, skid full -> skid dropped; flush; fetch resumes at target.
//  5 ADDR_WIDTH=4, RESET_PC=14 -> ifid_pc_o sequence 14,15,0,1.
//  6 rst_n low mid-stream with skid full -> outputs zero immediately; restart at RESET_PC; stale data never delivered.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared types and constants for the 20-bit pipelined core.
//  Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int IMEM_ADDR_WIDTH = 10;

    // All-zero word decodes as a harmless no-op in the downstream stages.
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 20'h0;

    typedef enum logic [2:0] {
        OP_ALUI   = 3'b010,
        OP_LOAD   = 3'b011,
        OP_STORE  = 3'b100,
        OP_BRANCH = 3'b101
    } opcode_t;

    typedef struct packed {
        logic                       valid;
        logic [DATA_WIDTH-1:0]      instr;
        logic [IMEM_ADDR_WIDTH-1:0] pc;
    } ifid_t;

    // Decode extracts the opcode from the low three instruction bits.
    function automatic logic [2:0] get_opcode(input logic [DATA_WIDTH-1:0] instr);
        return instr[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_skid_buf
//  Purpose  : One-entry holding buffer for a fetch word returned while
//             decode is stalled. Clear beats load beats consume.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_skid_buf #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  consume,
    input  logic [DATA_WIDTH-1:0] load_instr,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] pc_q;

    // Buffer state: capture on load, drop on clear or consume, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= load_instr;
            pc_q    <= load_pc;
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : PC sequencing, synchronous instruction-memory request and the
//             IF/ID pipeline register. Redirect beats stall beats run.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  ifid_valid_o,
    output logic [DATA_WIDTH-1:0] ifid_instr_o,
    output logic [ADDR_WIDTH-1:0] ifid_pc_o
);

    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE     = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_INSTR);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  req_valid_q;
    logic [ADDR_WIDTH-1:0] req_pc_q;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_instr;
    logic [ADDR_WIDTH-1:0] skid_pc;

    logic                  run;
    logic                  stall_only;

    assign run        = !redirect_i && !stall_i;
    assign stall_only = !redirect_i && stall_i;

    // Requests are gated by rst_n so the memory sees no read while in reset.
    assign imem_req_o  = rst_n && (redirect_i || !stall_i);
    assign imem_addr_o = (rst_n && redirect_i) ? redirect_pc_i : pc_q;

    // Data returned during a stall parks in the skid; redirect drops it.
    fetch_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect_i),
        .load       (stall_only && req_valid_q),
        .consume    (run),
        .load_instr (imem_rdata_i),
        .load_pc    (req_pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // PC sequencing and tracking of the request whose data arrives next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_ADDR;
            req_valid_q <= 1'b0;
            req_pc_q    <= RESET_ADDR;
        end else if (redirect_i) begin
            pc_q        <= redirect_pc_i + PC_ONE;
            req_valid_q <= 1'b1;
            req_pc_q    <= redirect_pc_i;
        end else if (stall_i) begin
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_q + PC_ONE;
            req_valid_q <= 1'b1;
            req_pc_q    <= pc_q;
        end
    end

    // IF/ID register: flush on redirect, hold on stall, skid first when running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_WORD;
            ifid_pc_o    <= '0;
        end else if (redirect_i) begin
            ifid_valid_o <= 1'b0;
            ifid_instr_o <= NOP_WORD;
        end else if (!stall_i) begin
            if (skid_valid) begin
                ifid_valid_o <= 1'b1;
                ifid_instr_o <= skid_instr;
                ifid_pc_o    <= skid_pc;
            end else if (req_valid_q) begin
                ifid_valid_o <= 1'b1;
                ifid_instr_o <= imem_rdata_i;
                ifid_pc_o    <= req_pc_q;
            end else begin
                ifid_valid_o <= 1'b0;
                ifid_instr_o <= NOP_WORD;
            end
        end
    end

    // A word is either in flight or parked, never both.
    a_skid_req_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(skid_valid && req_valid_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [9:0]  redirect_pc_i;
    logic        imem_req_o;
    logic [9:0]  imem_addr_o;
    logic [19:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [19:0] ifid_instr_o;
    logic [9:0]  ifid_pc_o;

    // Narrow-address instance for the wrap-around case.
    logic        rst2_n;
    logic        stall2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [3:0]  redirect_pc2 = 4'd0;
    logic        req2;
    logic [3:0]  addr2;
    logic [19:0] rdata2;
    logic        valid2;
    logic [19:0] instr2;
    logic [3:0]  pc2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.DATA_WIDTH(20), .ADDR_WIDTH(10), .RESET_PC(0)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc_o     (ifid_pc_o)
    );

    fetch_stage #(.DATA_WIDTH(20), .ADDR_WIDTH(4), .RESET_PC(14)) u_dut2 (
        .clk           (clk),
        .rst_n         (rst2_n),
        .stall_i       (stall2),
        .redirect_i    (redirect2),
        .redirect_pc_i (redirect_pc2),
        .imem_req_o    (req2),
        .imem_addr_o   (addr2),
        .imem_rdata_i  (rdata2),
        .ifid_valid_o  (valid2),
        .ifid_instr_o  (instr2),
        .ifid_pc_o     (pc2)
    );

    // Memory model: mem[a] = 20'h1000 + a, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req_o) imem_rdata_i <= 20'h01000 + {10'h0, imem_addr_o};
        if (req2)       rdata2       <= 20'h01000 + {16'h0, addr2};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks IF/ID of the main instance against an expected valid/pc/instr.
    task automatic expect_ifid(input string name, input logic v, input logic [9:0] p,
                               input logic [19:0] ins);
        checks++;
        if (ifid_valid_o !== v || ifid_pc_o !== p || ifid_instr_o !== ins) begin
            failures++;
            $display("FAIL %s: got valid=%0b pc=%0d instr=%h, expected valid=%0b pc=%0d instr=%h",
                     name, ifid_valid_o, ifid_pc_o, ifid_instr_o, v, p, ins);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        tick(); tick();
        checks++;
        if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 20'h0 || ifid_pc_o !== 10'd0) begin
            failures++;
            $display("FAIL reset_ifid: got valid=%0b instr=%h pc=%0d, expected 0/0/0",
                     ifid_valid_o, ifid_instr_o, ifid_pc_o);
        end
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 10'd0) begin
            failures++;
            $display("FAIL reset_imem: got req=%0b addr=%0d, expected req=0 addr=0",
                     imem_req_o, imem_addr_o);
        end
        checks++;
        if (req2 !== 1'b0 || addr2 !== 4'd14) begin
            failures++;
            $display("FAIL reset_imem_pc14: got req=%0b addr=%0d, expected req=0 addr=14",
                     req2, addr2);
        end
    endtask

    task automatic test_sequential_fetch();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 10'd0) begin
            failures++;
            $display("FAIL first_request: got req=%0b addr=%0d, expected req=1 addr=0",
                     imem_req_o, imem_addr_o);
        end
        tick();
        expect_ifid("seq_edge1_bubble", 1'b0, 10'd0, 20'h0);
        for (int e = 2; e <= 5; e++) begin
            tick();
            expect_ifid("seq_fetch", 1'b1, 10'(e - 2), 20'h01000 + 20'(e - 2));
        end
    endtask

    task automatic test_stall();
        tick();
        expect_ifid("pre_stall", 1'b1, 10'd4, 20'h01004);
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (imem_req_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_no_req: got req=%0b, expected 0", imem_req_o);
            end
            tick();
            expect_ifid("stall_hold", 1'b1, 10'd4, 20'h01004);
        end
        stall_i = 1'b0;
        tick();
        expect_ifid("stall_release_skid", 1'b1, 10'd5, 20'h01005);
        tick();
        expect_ifid("stall_release_next", 1'b1, 10'd6, 20'h01006);
    endtask

    task automatic test_redirect();
        redirect_i = 1'b1; redirect_pc_i = 10'd40;
        #1;
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 10'd40) begin
            failures++;
            $display("FAIL redirect_addr: got req=%0b addr=%0d, expected req=1 addr=40",
                     imem_req_o, imem_addr_o);
        end
        tick();
        expect_ifid("redirect_flush", 1'b0, 10'd6, 20'h0);
        redirect_i = 1'b0;
        tick();
        expect_ifid("redirect_target", 1'b1, 10'd40, 20'h01028);
        tick();
        expect_ifid("redirect_target_next", 1'b1, 10'd41, 20'h01029);
    endtask

    task automatic test_redirect_with_stall();
        stall_i = 1'b1;
        tick();
        expect_ifid("rs_stall_hold", 1'b1, 10'd41, 20'h01029);
        redirect_i = 1'b1; redirect_pc_i = 10'd100;
        tick();
        expect_ifid("rs_flush", 1'b0, 10'd41, 20'h0);
        redirect_i = 1'b0; stall_i = 1'b0;
        tick();
        expect_ifid("rs_target", 1'b1, 10'd100, 20'h01064);
        tick();
        expect_ifid("rs_target_next", 1'b1, 10'd101, 20'h01065);
    endtask

    task automatic test_addr_wrap();
        rst2_n = 1'b1;
        tick();
        for (int e = 2; e <= 5; e++) begin
            logic [3:0] ep;
            tick();
            ep = 4'(14 + e - 2);
            checks++;
            if (valid2 !== 1'b1 || pc2 !== ep || instr2 !== 20'h01000 + {16'h0, ep}) begin
                failures++;
                $display("FAIL wrap_seq: got valid=%0b pc=%0d instr=%h, expected valid=1 pc=%0d instr=%h",
                         valid2, pc2, instr2, ep, 20'h01000 + {16'h0, ep});
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        stall_i = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        expect_ifid("midreset_immediate", 1'b0, 10'd0, 20'h0);
        checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 10'd0) begin
            failures++;
            $display("FAIL midreset_imem: got req=%0b addr=%0d, expected req=0 addr=0",
                     imem_req_o, imem_addr_o);
        end
        stall_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        expect_ifid("midreset_no_stale", 1'b0, 10'd0, 20'h0);
        tick();
        expect_ifid("midreset_restart", 1'b1, 10'd0, 20'h01000);
        tick();
        expect_ifid("midreset_restart_next", 1'b1, 10'd1, 20'h01001);
    endtask

    initial begin
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect();
        test_redirect_with_stall();
        test_addr_wrap();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
